// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared encodings and constants for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

  // Operation encoding as presented on op_i by the decode stage.
  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  // Sequencer states: idle, iterating one bit per cycle, one-cycle completion.
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  // Widest operand the shared zero constant covers; slices of it clear the
  // W-bit and 2W-bit registers.
  localparam int MD_MAX_W = 64;
  localparam logic [2*MD_MAX_W-1:0] MD_ZERO = '0;

  // Signed variants iterate on magnitudes and need a sign fix at the end.
  function automatic logic mdIsSigned(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Both divide encodings share the upper opcode bit.
  function automatic logic mdIsDiv(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv_signfix.sv
// ex_muldiv_signfix: magnitude extraction of the incoming operands and sign
// restoration of the finished hi/lo result. Purely combinational.
module ex_muldiv_signfix
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] absA_o,
  output logic [WIDTH-1:0] absB_o,
  input  logic             isDiv_i,
  input  logic             negA_i,
  input  logic             negB_i,
  input  logic [WIDTH-1:0] rawHi_i,
  input  logic [WIDTH-1:0] rawLo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prodNeg;

  // Magnitudes of the operands; the most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  always_comb begin
    absA_o = (signed_i && a_i[WIDTH-1]) ? -a_i : a_i;
    absB_o = (signed_i && b_i[WIDTH-1]) ? -b_i : b_i;
  end

  // Product negates as a whole; quotient follows the sign product and the
  // remainder follows the dividend.
  always_comb begin
    prod    = {rawHi_i, rawLo_i};
    prodNeg = MD_ZERO[2*WIDTH-1:0] - prod;
    if (isDiv_i) begin
      lo_o = (negA_i ^ negB_i) ? -rawLo_i : rawLo_i;
      hi_o = negA_i ? -rawHi_i : rawHi_i;
    end else if (negA_i ^ negB_i) begin
      {hi_o, lo_o} = prodNeg;
    end else begin
      {hi_o, lo_o} = prod;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative MULT/MULTU/DIV/DIVU unit beside the EX-stage ALU.
// One bit per cycle on a shared 2W shift register; result lands in hi_o/lo_o.
// Define EX_MULDIV_DIV_EN to build the restoring divider; without it DIV/DIVU
// finish one cycle after acceptance with zero results.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             dbz_o
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               isDiv_q, isDiv_d;
  logic               negA_q, negA_d;
  logic               negB_q, negB_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               dbz_q, dbz_d;

  logic               accept;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH-1:0]   fixHi, fixLo;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] stepAcc;
`ifdef EX_MULDIV_DIV_EN
  logic [WIDTH:0]     remShift;
  logic [WIDTH:0]     remDiff;
`endif

  assign accept = (state_q == MD_IDLE) && start_i && !cancel_i;

  ex_muldiv_signfix #(
    .WIDTH(WIDTH)
  ) uSignfix (
    .signed_i (mdIsSigned(op_i)),
    .a_i      (opa_i),
    .b_i      (opb_i),
    .absA_o   (absA),
    .absB_o   (absB),
    .isDiv_i  (isDiv_q),
    .negA_i   (negA_q),
    .negB_i   (negB_q),
    .rawHi_i  (stepAcc[2*WIDTH-1:WIDTH]),
    .rawLo_i  (stepAcc[WIDTH-1:0]),
    .hi_o     (fixHi),
    .lo_o     (fixLo)
  );

  // One iteration of the shared register: shift-add for multiply, shift-subtract for divide.
  always_comb begin
    mulSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + (acc_q[0] ? {1'b0, opnd_q} : {1'b0, MD_ZERO[WIDTH-1:0]});
    stepAcc = {mulSum, acc_q[WIDTH-1:1]};
`ifdef EX_MULDIV_DIV_EN
    remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    remDiff  = remShift - {1'b0, opnd_q};
    if (isDiv_q) begin
      if (remDiff[WIDTH]) begin
        stepAcc = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        stepAcc = {remDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end
`endif
  end

  // Sequencer: accept in IDLE, iterate WIDTH times in RUN, publish result entering DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    isDiv_d = isDiv_q;
    negA_d  = negA_q;
    negB_d  = negB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          isDiv_d = mdIsDiv(op_i);
          negA_d  = mdIsSigned(op_i) && opa_i[WIDTH-1];
          negB_d  = mdIsSigned(op_i) && opb_i[WIDTH-1];
          cnt_d   = MD_ZERO[CNT_W-1:0];
          if (mdIsDiv(op_i)) begin
`ifdef EX_MULDIV_DIV_EN
            if (opb_i == MD_ZERO[WIDTH-1:0]) begin
              state_d = MD_DONE;
              hi_d    = opa_i;
              lo_d    = ~MD_ZERO[WIDTH-1:0];
              dbz_d   = 1'b1;
            end else begin
              state_d = MD_RUN;
              acc_d   = {MD_ZERO[WIDTH-1:0], absA};
              opnd_d  = absB;
            end
`else
            state_d = MD_DONE;
            hi_d    = MD_ZERO[WIDTH-1:0];
            lo_d    = MD_ZERO[WIDTH-1:0];
`endif
          end else begin
            state_d = MD_RUN;
            acc_d   = {MD_ZERO[WIDTH-1:0], absB};
            opnd_d  = absA;
          end
        end
      end
      MD_RUN: begin
        if (cancel_i) begin
          state_d = MD_IDLE;
          cnt_d   = MD_ZERO[CNT_W-1:0];
        end else begin
          acc_d = stepAcc;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = MD_DONE;
            cnt_d   = MD_ZERO[CNT_W-1:0];
            hi_d    = fixHi;
            lo_d    = fixLo;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      MD_DONE: begin
        state_d = MD_IDLE;
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= MD_ZERO[CNT_W-1:0];
      acc_q   <= MD_ZERO[2*WIDTH-1:0];
      opnd_q  <= MD_ZERO[WIDTH-1:0];
      isDiv_q <= 1'b0;
      negA_q  <= 1'b0;
      negB_q  <= 1'b0;
      hi_q    <= MD_ZERO[WIDTH-1:0];
      lo_q    <= MD_ZERO[WIDTH-1:0];
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      isDiv_q <= isDiv_d;
      negA_q  <= negA_d;
      negB_q  <= negB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy_o  = (state_q != MD_IDLE);
  assign stall_o = accept || (state_q == MD_RUN);
  assign done_o  = (state_q == MD_DONE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign dbz_o   = dbz_q;

endmodule
